// File: rtl/word_array_ctrl.sv
// Initiator-side sequencer for the latch-based word array: setup/strobe/hold timing on select, rw and data-in.
// Optional build macro WORD_ARRAY_CTRL_VERIFY_EN adds a read-back compare after every write.
module word_array_ctrl #(
  parameter int NWORDS    = 4,
  parameter int AW        = $clog2(NWORDS),
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AW-1:0]     req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_rdata,
  output logic              resp_err,
  output logic [NWORDS-1:0] mem_sel_n,
  output logic              mem_rw,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAXC - 1);
  localparam logic [AW:0]   NW_EXT     = (AW+1)'(NWORDS);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic          accept;
  logic          addr_bad;
`ifdef WORD_ARRAY_CTRL_VERIFY_EN
  logic [7:0]    wdata_q;
  logic          verify_q;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_bad  = ({1'b0, req_addr} >= NW_EXT);
  // Phase counter never wraps; it is cleared on every phase change.
  assign cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      mem_sel_n  <= '1;
      mem_rw     <= 1'b0;
      mem_din    <= 8'h00;
      resp_valid <= 1'b0;
      resp_rdata <= 8'h00;
      resp_err   <= 1'b0;
`ifdef WORD_ARRAY_CTRL_VERIFY_EN
      wdata_q    <= 8'h00;
      verify_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= req_addr;
            write_q    <= req_write;
            cnt        <= '0;
            resp_rdata <= 8'h00;
            resp_err   <= 1'b0;
`ifdef WORD_ARRAY_CTRL_VERIFY_EN
            wdata_q    <= req_wdata;
            verify_q   <= 1'b0;
`endif
            if (addr_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state   <= SETUP;
              mem_rw  <= req_write;
              mem_din <= req_write ? req_wdata : 8'h00;
            end
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state     <= ACCESS;
            cnt       <= '0;
            mem_sel_n <= ~(NWORDS'(1) << addr_q);
          end else begin
            cnt <= cnt_next;
          end
        end
        ACCESS: begin
          // Read data is captured on the same edge that releases the select.
          if (cnt == PULSE_LAST) begin
            state     <= HOLD;
            cnt       <= '0;
            mem_sel_n <= '1;
            if (!write_q) resp_rdata <= mem_dout;
`ifdef WORD_ARRAY_CTRL_VERIFY_EN
            else if (verify_q) begin
              resp_rdata <= mem_dout;
              resp_err   <= (mem_dout != wdata_q);
            end
`endif
          end else begin
            cnt <= cnt_next;
          end
        end
        HOLD: begin
`ifdef WORD_ARRAY_CTRL_VERIFY_EN
          if (write_q && !verify_q) begin
            verify_q <= 1'b1;
            mem_rw   <= 1'b0;
            cnt      <= '0;
            state    <= SETUP;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
`else
          state      <= RESP;
          resp_valid <= 1'b1;
`endif
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            mem_rw     <= 1'b0;
            mem_din    <= 8'h00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
